dm_access_arbiter: RTL and testbench

Shares the single-port 32x32 data memory between two requesters: port C (CPU MEM stage, high priority) and port D (debug/loader, low priority, starvation-protected). It latches one request at a time and drives the memory's address, write-data and write strobe. Each write is sequenced as a clean setup-then-strobe pulse on the memory's edge-triggered write input, and each read word is captured into a registered response.

---
 rtl/dm_arb_pkg.sv | 25 ++
 rtl/dm_access_arbiter_if.sv | 47 ++++
 rtl/dm_arb_pick.sv | 13 +
 rtl/dm_access_arbiter.sv | 140 ++++++++++++++
 tb/tb_dm_access_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and defaults for the data-memory access arbiter
package dm_arb_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_DEF      = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WSTROBE = 2'd2,
        RCAP    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// rtl/dm_access_arbiter_if.sv - requester ports C/D plus the memory side of the arbiter
interface dm_access_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;
    logic              c_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din;
    logic [DATA_W-1:0] dm_dout;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_done, c_rdata, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata, d_err,
        input  dm_wr, dm_addr, dm_din,
        output dm_dout
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_done, c_rdata, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata, d_err,
        output dm_wr, dm_addr, dm_din,
        input  dm_dout
    );

endinterface

// File: rtl/dm_arb_pick.sv
// rtl/dm_arb_pick.sv - fixed C-over-D priority, overridden once D has starved
module dm_arb_pick (
    input  logic c_req_i,
    input  logic d_req_i,
    input  logic starved_i,
    output logic grant_c_o,
    output logic grant_d_o
);

    assign grant_d_o = d_req_i & (~c_req_i | starved_i);
    assign grant_c_o = c_req_i & ~grant_d_o;

endmodule

// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - two-port arbiter sequencing setup/strobe writes and captured reads
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dm_access_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_e            state_q;
    owner_e            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;

    logic              c_gnt_q, c_done_q, c_err_q;
    logic              d_gnt_q, d_done_q, d_err_q;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
    logic              dm_wr_q;

    logic              grant_c, grant_d;
    logic              starved;
    logic              in_range;
    logic [DATA_W-1:0] rdata_cap;

    assign starved   = (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign in_range  = addr_in_range(32'(addr_q), DEPTH);
    assign rdata_cap = (!we_q && in_range) ? bus.dm_dout : '0;

    dm_arb_pick u_pick (
        .c_req_i   (bus.c_req),
        .d_req_i   (bus.d_req),
        .starved_i (starved),
        .grant_c_o (grant_c),
        .grant_d_o (grant_d)
    );

    // Only meaningful in IDLE; a D loss counts up, any D win or D absence clears.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.d_req || grant_d) begin
            starve_cnt_d = '0;
        end else if (grant_c && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_C;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_cnt_q <= '0;
            c_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            c_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            c_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
            dm_wr_q      <= 1'b0;
        end else begin
            c_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            c_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            c_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            dm_wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (grant_c || grant_d) begin
                        owner_q <= grant_d ? OWN_D : OWN_C;
                        we_q    <= grant_d ? bus.d_we    : bus.c_we;
                        addr_q  <= grant_d ? bus.d_addr  : bus.c_addr;
                        wdata_q <= grant_d ? bus.d_wdata : bus.c_wdata;
                        c_gnt_q <= grant_c;
                        d_gnt_q <= grant_d;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (we_q && in_range) begin
                        dm_wr_q <= 1'b1;
                        state_q <= WSTROBE;
                    end else begin
                        state_q <= RCAP;
                    end
                end
                WSTROBE: begin
                    c_done_q <= (owner_q == OWN_C);
                    d_done_q <= (owner_q == OWN_D);
                    state_q  <= IDLE;
                end
                RCAP: begin
                    // Out-of-range writes also land here, so no strobe is ever issued for them.
                    if (owner_q == OWN_D) begin
                        d_done_q  <= 1'b1;
                        d_err_q   <= !in_range;
                        d_rdata_q <= rdata_cap;
                    end else begin
                        c_done_q  <= 1'b1;
                        c_err_q   <= !in_range;
                        c_rdata_q <= rdata_cap;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.c_gnt   = c_gnt_q;
    assign bus.c_done  = c_done_q;
    assign bus.c_err   = c_err_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_gnt   = d_gnt_q;
    assign bus.d_done  = d_done_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.dm_wr   = dm_wr_q;
    assign bus.dm_addr = addr_q;
    assign bus.dm_din  = wdata_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - directed self-checking bench for dm_access_arbiter
module tb_dm_access_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b0;

    always #5 clk = ~clk;

    dm_access_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dm_access_arbiter #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(32), .STARVE_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: async read, write on the rising edge of dm_wr.
    logic [31:0] mem [32];
    always @(posedge bus.dm_wr or posedge mem_init) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.dm_addr < 10'd32) begin
            mem[bus.dm_addr[4:0]] <= bus.dm_din;
        end
    end
    assign bus.dm_dout = (bus.dm_addr < 10'd32) ? mem[bus.dm_addr[4:0]] : 32'h0;

    int wr_cnt = 0, wr_b2b = 0, c_done_cnt = 0, d_done_cnt = 0, both_gnt = 0;
    logic wr_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.dm_wr) wr_cnt++;
        if (bus.dm_wr && wr_prev) wr_b2b++;
        wr_prev = bus.dm_wr;
        if (bus.c_done) c_done_cnt++;
        if (bus.d_done) d_done_cnt++;
        if (bus.c_gnt && bus.d_gnt) both_gnt++;
    end

    logic        c_req_p = 1'b0, c_gnt_p = 1'b0, d_req_p = 1'b0, d_gnt_p = 1'b0;
    logic [42:0] c_bits_p = '0, d_bits_p = '0;
    always @(posedge clk) begin
        if (!rst && c_req_p && !c_gnt_p && bus.c_req)
            assert ({bus.c_we, bus.c_addr, bus.c_wdata} == c_bits_p)
                else $error("protocol violation: port C changed before grant");
        if (!rst && d_req_p && !d_gnt_p && bus.d_req)
            assert ({bus.d_we, bus.d_addr, bus.d_wdata} == d_bits_p)
                else $error("protocol violation: port D changed before grant");
        c_req_p  <= bus.c_req;
        c_gnt_p  <= bus.c_gnt;
        c_bits_p <= {bus.c_we, bus.c_addr, bus.c_wdata};
        d_req_p  <= bus.d_req;
        d_gnt_p  <= bus.d_gnt;
        d_bits_p <= {bus.d_we, bus.d_addr, bus.d_wdata};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit pd, input bit r, input bit we,
                             input logic [9:0] a, input logic [31:0] w);
        if (pd) begin
            bus.d_req = r; bus.d_we = we; bus.d_addr = a; bus.d_wdata = w;
        end else begin
            bus.c_req = r; bus.c_we = we; bus.c_addr = a; bus.c_wdata = w;
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic access(input bit pd, input bit we, input logic [9:0] a, input logic [31:0] w,
                          output logic [31:0] rd, output logic er, output int gl, output int dl);
        gl = -1; dl = -1; rd = '0; er = 1'b0;
        drive_req(pd, 1'b1, we, a, w);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (pd ? bus.d_gnt : bus.c_gnt) begin gl = n; break; end
        end
        drive_req(pd, 1'b0, we, a, w);
        if (gl > 0) begin
            for (int n = gl + 1; n <= gl + 20; n++) begin
                @(negedge clk);
                if (pd ? bus.d_done : bus.c_done) begin
                    dl = n;
                    rd = pd ? bus.d_rdata : bus.c_rdata;
                    er = pd ? bus.d_err : bus.c_err;
                    break;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        er;
    int          gl, dl, w0, cd0, dd0, ng, act;
    logic [9:0]  seq;

    initial begin
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        #1 mem_init = 1'b1;
        #1 mem_init = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_flags", {57'd0, bus.c_gnt, bus.d_gnt, bus.c_done, bus.d_done,
                          bus.c_err, bus.d_err, bus.dm_wr}, 64'd0);
        chk("rst_dm_addr", {54'd0, bus.dm_addr}, 64'd0);
        chk("rst_dm_din", {32'd0, bus.dm_din}, 64'd0);
        chk("rst_rdata", {bus.c_rdata, bus.d_rdata}, 64'd0);
        chk("rst_state", {62'd0, dut.state_q}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // C write 5, observing setup and strobe cycles.
        w0 = wr_cnt;
        drive_req(1'b0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_setup_gnt", {63'd0, bus.c_gnt}, 64'd1);
        chk("wr_setup_nowr", {63'd0, bus.dm_wr}, 64'd0);
        chk("wr_setup_addr", {54'd0, bus.dm_addr}, 64'd5);
        chk("wr_setup_din", {32'd0, bus.dm_din}, 64'hDEADBEEF);
        drive_req(1'b0, 1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_strobe", {63'd0, bus.dm_wr}, 64'd1);
        @(negedge clk);
        chk("wr_done", {62'd0, bus.c_done, bus.c_err}, 64'b10);
        chk("wr_strobe_off", {63'd0, bus.dm_wr}, 64'd0);
        @(negedge clk);
        chk("wr_pulses", 64'(wr_cnt - w0), 64'd1);

        access(1'b0, 1'b0, 10'd5, 32'h0, rd, er, gl, dl);
        chk("rd5_gnt_lat", 64'(gl), 64'd1);
        chk("rd5_done_lat", 64'(dl), 64'd3);
        chk("rd5_data", {32'd0, rd}, 64'hDEADBEEF);
        chk("rd5_err", {63'd0, er}, 64'd0);
        @(negedge clk);

        // Both ports request reads continuously: expect C C C C D repeating.
        cd0 = c_done_cnt; dd0 = d_done_cnt;
        drive_req(1'b0, 1'b1, 1'b0, 10'd1, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 10'd2, 32'h0);
        seq = '0; ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
            @(negedge clk);
            if (bus.c_gnt || bus.d_gnt) begin
                seq[ng] = bus.d_gnt;
                ng++;
            end
        end
        drive_req(1'b0, 1'b0, 1'b0, 10'd1, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 10'd2, 32'h0);
        repeat (6) @(negedge clk);
        chk("starve_ngrants", 64'(ng), 64'd10);
        chk("starve_seq", {54'd0, seq}, 64'b10_0001_0000);
        chk("starve_c_done", 64'(c_done_cnt - cd0), 64'd8);
        chk("starve_d_done", 64'(d_done_cnt - dd0), 64'd2);
        chk("starve_both_gnt", 64'(both_gnt), 64'd0);

        // Out-of-range D accesses.
        access(1'b1, 1'b0, 10'd40, 32'h0, rd, er, gl, dl);
        chk("oor_rd_lat", 64'(dl), 64'd3);
        chk("oor_rd_err", {63'd0, er}, 64'd1);
        chk("oor_rd_data", {32'd0, rd}, 64'd0);
        w0 = wr_cnt;
        access(1'b1, 1'b1, 10'd40, 32'hCAFEF00D, rd, er, gl, dl);
        chk("oor_wr_lat", 64'(dl), 64'd3);
        chk("oor_wr_err", {63'd0, er}, 64'd1);
        chk("oor_wr_data", {32'd0, rd}, 64'd0);
        chk("oor_wr_nostrobe", 64'(wr_cnt - w0), 64'd0);
        access(1'b0, 1'b0, 10'd8, 32'h0, rd, er, gl, dl);
        chk("oor_alias_intact", {32'd0, rd}, 64'hA500_0008);
        @(negedge clk);

        // Reset while a C write to 3 sits in SETUP.
        w0 = wr_cnt; cd0 = c_done_cnt;
        drive_req(1'b0, 1'b1, 1'b1, 10'd3, 32'h3333_3333);
        @(negedge clk);
        chk("rstmid_gnt", {63'd0, bus.c_gnt}, 64'd1);
        rst = 1'b1;
        drive_req(1'b0, 1'b0, 1'b1, 10'd3, 32'h3333_3333);
        @(negedge clk);
        chk("rstmid_flags", {57'd0, bus.c_gnt, bus.d_gnt, bus.c_done, bus.d_done,
                             bus.c_err, bus.d_err, bus.dm_wr}, 64'd0);
        chk("rstmid_dm", {bus.dm_din, 22'd0, bus.dm_addr}, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_nostrobe", 64'(wr_cnt - w0), 64'd0);
        chk("rstmid_nodone", 64'(c_done_cnt - cd0), 64'd0);
        access(1'b0, 1'b0, 10'd3, 32'h0, rd, er, gl, dl);
        chk("rstmid_addr3", {32'd0, rd}, 64'hA500_0003);
        @(negedge clk);

        // D write 7 then C read 7 issued in the done cycle.
        access(1'b1, 1'b1, 10'd7, 32'h11, rd, er, gl, dl);
        chk("b2b_wr_lat", 64'(dl), 64'd3);
        chk("b2b_wr_err", {63'd0, er}, 64'd0);
        access(1'b0, 1'b0, 10'd7, 32'h0, rd, er, gl, dl);
        chk("b2b_rd_gnt_lat", 64'(gl), 64'd1);
        chk("b2b_rd_data", {32'd0, rd}, 64'h11);
        @(negedge clk);

        // Idle bus.
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.c_gnt || bus.d_gnt || bus.c_done || bus.d_done || bus.dm_wr) act++;
        end
        chk("idle_activity", 64'(act), 64'd0);
        chk("idle_starve_cnt", 64'(dut.starve_cnt_q), 64'd0);
        chk("never_b2b_strobe", 64'(wr_b2b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
